// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-window sequencer.
// The GAP state exists only when SHIFT_SEQ_GAP_EN is defined.
package shift_seq_pkg;

   localparam int DEF_SIZESRDYN  = 16;
   localparam int DEF_SIZESRSTAT = 88;
   localparam int DEF_GAP_CYCLES = 4;

   localparam logic [1:0] MODE_DYN      = 2'b00;
   localparam logic [1:0] MODE_STAT     = 2'b01;
   localparam logic [1:0] MODE_DYN_STAT = 2'b10;
   localparam logic [1:0] MODE_STAT_DYN = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEG1 = 3'd1,
`ifdef SHIFT_SEQ_GAP_EN
      ST_GAP  = 3'd2,
`endif
      ST_SEG2 = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   function automatic logic first_is_dyn(input logic [1:0] mode);
      return (mode == MODE_DYN) || (mode == MODE_DYN_STAT);
   endfunction

endpackage

// File: rtl/seg_counter.sv
// Loadable down-counter with a zero flag; stops at zero, load wins over decrement.
module seg_counter #(
   parameter int CNT_W = 7
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Sequences dynamic/static shift-window selects for a downstream serial generator.
// Define SHIFT_SEQ_GAP_EN to insert GAP_CYCLES idle cycles between segments and frames.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int SIZESRDYN  = DEF_SIZESRDYN,
   parameter int SIZESRSTAT = DEF_SIZESRSTAT,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int CNT_W      = 7
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic       ABORT,
   input  logic [1:0] MODE,
   input  logic [3:0] REPEAT,
   output logic       SELDYN,
   output logic       SELSTAT,
   output logic       BIT_VALID,
   output logic       BUSY,
   output logic       DONE,
   output logic [3:0] FRAME_CNT
);

   if (SIZESRDYN < 2 || SIZESRDYN > 127 || SIZESRSTAT < 2 || SIZESRSTAT > 127 ||
       GAP_CYCLES < 1 || GAP_CYCLES > 127 || CNT_W < 7) begin : g_param_check
      $error("shift_sequencer: parameter out of range");
   end

   localparam logic [CNT_W-1:0] DYN_LAST  = CNT_W'(SIZESRDYN - 1);
   localparam logic [CNT_W-1:0] STAT_LAST = CNT_W'(SIZESRSTAT - 1);

   state_t           state_q, state_d;
   logic [1:0]       mode_q;
   logic [3:0]       repeat_q;
   logic [3:0]       frame_cnt_q;
   logic             latch_cfg, fc_clr, fc_inc, frame_end;
   logic             bit_load, bit_dec, bit_zero;
   logic [CNT_W-1:0] bit_val, bit_count;
   logic             seg1_dyn, more_frames;
   logic [CNT_W-1:0] seg1_last, seg2_last;
   logic             bit_valid_p1;

   assign seg1_dyn    = first_is_dyn(mode_q);
   assign seg1_last   = seg1_dyn ? DYN_LAST : STAT_LAST;
   assign seg2_last   = seg1_dyn ? STAT_LAST : DYN_LAST;
   // frame_cnt_q still holds the count before the frame now ending
   assign more_frames = (frame_cnt_q != repeat_q);
   assign bit_dec     = (state_q == ST_SEG1) || (state_q == ST_SEG2);

   seg_counter #(.CNT_W(CNT_W)) u_bit_cnt (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .load     (bit_load),
      .load_val (bit_val),
      .dec      (bit_dec),
      .count    (bit_count),
      .zero     (bit_zero)
   );

`ifdef SHIFT_SEQ_GAP_EN
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   logic             gap_load, gap_zero, gap_wr, gap_nxt, gap_to_seg2_q;
   logic [CNT_W-1:0] gap_count;

   seg_counter #(.CNT_W(CNT_W)) u_gap_cnt (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .load     (gap_load),
      .load_val (GAP_LAST),
      .dec      (state_q == ST_GAP),
      .count    (gap_count),
      .zero     (gap_zero)
   );

   // Remembers whether the current gap leads into SEG2 or into the next frame's SEG1
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         gap_to_seg2_q <= 1'b0;
      end else if (gap_wr) begin
         gap_to_seg2_q <= gap_nxt;
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      latch_cfg = 1'b0;
      fc_clr    = 1'b0;
      fc_inc    = 1'b0;
      frame_end = 1'b0;
      bit_load  = 1'b0;
      bit_val   = seg1_last;
`ifdef SHIFT_SEQ_GAP_EN
      gap_load  = 1'b0;
      gap_wr    = 1'b0;
      gap_nxt   = 1'b0;
`endif
      if ((state_q != ST_IDLE) && ABORT) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (START && !ABORT) begin
                  state_d   = ST_SEG1;
                  latch_cfg = 1'b1;
                  fc_clr    = 1'b1;
                  bit_load  = 1'b1;
                  bit_val   = first_is_dyn(MODE) ? DYN_LAST : STAT_LAST;
               end
            end
            ST_SEG1: begin
               if (bit_zero) begin
                  if (mode_q[1]) begin
`ifdef SHIFT_SEQ_GAP_EN
                     state_d  = ST_GAP;
                     gap_load = 1'b1;
                     gap_wr   = 1'b1;
                     gap_nxt  = 1'b1;
`else
                     state_d  = ST_SEG2;
                     bit_load = 1'b1;
                     bit_val  = seg2_last;
`endif
                  end else begin
                     frame_end = 1'b1;
                  end
               end
            end
`ifdef SHIFT_SEQ_GAP_EN
            ST_GAP: begin
               if (gap_zero) begin
                  bit_load = 1'b1;
                  if (gap_to_seg2_q) begin
                     state_d = ST_SEG2;
                     bit_val = seg2_last;
                  end else begin
                     state_d = ST_SEG1;
                     bit_val = seg1_last;
                  end
               end
            end
`endif
            ST_SEG2: begin
               if (bit_zero) begin
                  frame_end = 1'b1;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase

         if (frame_end) begin
            fc_inc = 1'b1;
            if (more_frames) begin
`ifdef SHIFT_SEQ_GAP_EN
               state_d  = ST_GAP;
               gap_load = 1'b1;
               gap_wr   = 1'b1;
               gap_nxt  = 1'b0;
`else
               state_d  = ST_SEG1;
               bit_load = 1'b1;
               bit_val  = seg1_last;
`endif
            end else begin
               state_d = ST_DONE;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= 4'd0;
      end else begin
         state_q <= state_d;
         if (fc_clr) begin
            frame_cnt_q <= 4'd0;
         end else if (fc_inc) begin
            frame_cnt_q <= frame_cnt_q + 4'd1;
         end
      end
   end

   // Configuration is only consumed while busy, so it needs no reset
   always_ff @(posedge CLK) begin
      if (latch_cfg) begin
         mode_q   <= MODE;
         repeat_q <= REPEAT;
      end
   end

   assign SELDYN  = ((state_q == ST_SEG1) &&  seg1_dyn) || ((state_q == ST_SEG2) && !seg1_dyn);
   assign SELSTAT = ((state_q == ST_SEG1) && !seg1_dyn) || ((state_q == ST_SEG2) &&  seg1_dyn);

   // Stage p1: aligns with the generator's registered serial output
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bit_valid_p1 <= 1'b0;
      end else begin
         bit_valid_p1 <= SELDYN | SELSTAT;
      end
   end

   assign BIT_VALID = bit_valid_p1;
   assign BUSY      = (state_q != ST_IDLE);
   assign DONE      = (state_q == ST_DONE);
   assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer against a segment-list reference model.
// Honours SHIFT_SEQ_GAP_EN the same way as the design.
module tb_shift_sequencer;

   localparam int DYN  = 16;
   localparam int STAT = 88;
`ifdef SHIFT_SEQ_GAP_EN
   localparam int GAP  = 4;
`else
   localparam int GAP  = 0;
`endif

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       START = 1'b0;
   logic       ABORT = 1'b0;
   logic [1:0] MODE = 2'b00;
   logic [3:0] REPEAT = 4'd0;
   logic       SELDYN, SELSTAT, BIT_VALID, BUSY, DONE;
   logic [3:0] FRAME_CNT;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0] exp_q[$];
   logic [4:0] obs_q[$];
   int         ncyc, done_cyc, done_exp, done_seen;
   logic [3:0] fc_exp, fc_obs;

   shift_sequencer dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .START     (START),
      .ABORT     (ABORT),
      .MODE      (MODE),
      .REPEAT    (REPEAT),
      .SELDYN    (SELDYN),
      .SELSTAT   (SELSTAT),
      .BIT_VALID (BIT_VALID),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .FRAME_CNT (FRAME_CNT)
   );

   always #5 CLK = ~CLK;

   // Expected per-cycle {SELDYN,SELSTAT,BIT_VALID,BUSY,DONE}, cycle 1 first
   task automatic build_model(input logic [1:0] m, input int rep, input int abort_at);
      logic [1:0] sel[$];
      int         fends[$];
      logic [1:0] s_c, prev;
      logic       bsy, dn, fd;
      int         len, cnt;
      fd = (m == 2'b00) || (m == 2'b10);
      for (int f = 0; f <= rep; f++) begin
         if (f > 0) for (int g = 0; g < GAP; g++) sel.push_back(2'b00);
         for (int sg = 0; sg < (m[1] ? 2 : 1); sg++) begin
            logic dyn;
            dyn = (sg == 0) ? fd : !fd;
            if (sg > 0) for (int g = 0; g < GAP; g++) sel.push_back(2'b00);
            len = dyn ? DYN : STAT;
            for (int b = 0; b < len; b++) sel.push_back(dyn ? 2'b10 : 2'b01);
         end
         fends.push_back(sel.size());
      end
      done_cyc = sel.size() + 1;
      ncyc     = done_cyc + 2;
      exp_q    = {};
      prev     = 2'b00;
      for (int c = 1; c <= ncyc; c++) begin
         s_c = (c <= sel.size()) ? sel[c-1] : 2'b00;
         bsy = (c <= done_cyc);
         dn  = (c == done_cyc);
         if (abort_at > 0 && c > abort_at) begin
            s_c = 2'b00;
            bsy = 1'b0;
            dn  = 1'b0;
         end
         exp_q.push_back({s_c, |prev, bsy, dn});
         prev = s_c;
      end
      if (abort_at > 0) begin
         cnt = 0;
         foreach (fends[i]) if (fends[i] < abort_at) cnt++;
         done_exp = 0;
      end else begin
         cnt      = rep + 1;
         done_exp = 1;
      end
      fc_exp = 4'(cnt);
   endtask

   // Drives one START and records outputs for ncyc cycles; no checking here
   task automatic drive_seq(input logic [1:0] m, input int rep, input int abort_at,
                            input int start_at, input bit scramble, input int n);
      @(negedge CLK);
      MODE   = m;
      REPEAT = 4'(rep);
      START  = 1'b1;
      ABORT  = 1'b0;
      obs_q  = {};
      done_seen = 0;
      for (int k = 1; k <= n; k++) begin
         @(negedge CLK);
         obs_q.push_back({SELDYN, SELSTAT, BIT_VALID, BUSY, DONE});
         if (DONE) done_seen++;
         START = (k == start_at);
         ABORT = (k == abort_at);
         if (scramble) begin
            MODE   = 2'($urandom);
            REPEAT = 4'($urandom);
         end
      end
      START  = 1'b0;
      ABORT  = 1'b0;
      fc_obs = FRAME_CNT;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      n_tests++;
      if ({SELDYN, SELSTAT, BIT_VALID, BUSY, DONE} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got %b expected 00000", {SELDYN, SELSTAT, BIT_VALID, BUSY, DONE});
      end
      n_tests++;
      if (FRAME_CNT !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_frame_cnt got %0d expected 0", FRAME_CNT);
      end
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_modes();
      logic [1:0] modes[3];
      int         reps[3];
      modes = '{2'b00, 2'b10, 2'b01};
      reps  = '{0, 0, 2};
      for (int t = 0; t < 3; t++) begin
         build_model(modes[t], reps[t], 0);
         drive_seq(modes[t], reps[t], 0, 0, 1'b0, ncyc);
         foreach (exp_q[i]) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL mode%b cycle %0d got %b expected %b", modes[t], i + 1, obs_q[i], exp_q[i]);
            end
         end
         n_tests++;
         if (fc_obs !== fc_exp || done_seen != done_exp) begin
            n_fail++;
            $display("FAIL mode%b_end frame_cnt %0d dones %0d expected %0d / %0d",
                     modes[t], fc_obs, done_seen, fc_exp, done_exp);
         end
      end
   endtask

   task automatic test_abort();
      logic [3:0] fc_hold;
      build_model(2'b00, 0, 10);
      drive_seq(2'b00, 0, 10, 0, 1'b0, ncyc);
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL abort cycle %0d got %b expected %b", i + 1, obs_q[i], exp_q[i]);
         end
      end
      n_tests++;
      if (fc_obs !== fc_exp || done_seen != 0) begin
         n_fail++;
         $display("FAIL abort_end frame_cnt %0d dones %0d expected %0d / 0", fc_obs, done_seen, fc_exp);
      end
      fc_hold = FRAME_CNT;
      @(negedge CLK);
      START = 1'b1;
      ABORT = 1'b1;
      MODE  = 2'b01;
      for (int k = 1; k <= 20; k++) begin
         @(negedge CLK);
         START = 1'b0;
         ABORT = 1'b0;
         n_tests++;
         if ({SELDYN, SELSTAT, BUSY, DONE} !== 4'b0 || FRAME_CNT !== fc_hold) begin
            n_fail++;
            $display("FAIL start_abort_idle cycle %0d got %b/%0d expected 0000/%0d",
                     k, {SELDYN, SELSTAT, BUSY, DONE}, FRAME_CNT, fc_hold);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge CLK);
      MODE   = 2'b11;
      REPEAT = 4'd1;
      START  = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge CLK);
         START = 1'b0;
      end
      n_tests++;
      if (SELSTAT !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_selstat got %b expected 1", SELSTAT);
      end
      RST_N = 1'b0;
      #1;
      n_tests++;
      if ({SELDYN, SELSTAT, BIT_VALID, BUSY, DONE, FRAME_CNT} !== 9'b0) begin
         n_fail++;
         $display("FAIL mid_reset got %b expected 000000000",
                  {SELDYN, SELSTAT, BIT_VALID, BUSY, DONE, FRAME_CNT});
      end
      @(negedge CLK);
      RST_N = 1'b1;
      build_model(2'b11, 0, 0);
      drive_seq(2'b11, 0, 0, 0, 1'b0, ncyc);
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL restart cycle %0d got %b expected %b", i + 1, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_start_ignored();
      build_model(2'b00, 0, 0);
      drive_seq(2'b00, 0, 0, 5, 1'b0, ncyc);
      foreach (exp_q[i]) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL start_ignored cycle %0d got %b expected %b", i + 1, obs_q[i], exp_q[i]);
         end
      end
      n_tests++;
      if (done_seen != 1 || fc_obs !== 4'd1) begin
         n_fail++;
         $display("FAIL start_ignored_end dones %0d frame_cnt %0d expected 1 / 1", done_seen, fc_obs);
      end
   endtask

   task automatic test_random();
      logic [1:0] m;
      int         rep, ab, st;
      for (int t = 0; t < 8; t++) begin
         m   = 2'($urandom_range(0, 3));
         rep = $urandom_range(0, 3);
         build_model(m, rep, 0);
         ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(2, done_cyc - 1) : 0;
         st  = (ab == 0) ? $urandom_range(2, done_cyc) : 0;
         build_model(m, rep, ab);
         drive_seq(m, rep, ab, st, 1'b1, ncyc);
         foreach (exp_q[i]) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL random%0d m%b r%0d ab%0d cycle %0d got %b expected %b",
                        t, m, rep, ab, i + 1, obs_q[i], exp_q[i]);
            end
         end
         n_tests++;
         if (fc_obs !== fc_exp || done_seen != done_exp) begin
            n_fail++;
            $display("FAIL random%0d_end frame_cnt %0d dones %0d expected %0d / %0d",
                     t, fc_obs, done_seen, fc_exp, done_exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_abort();
      test_reset_mid();
      test_start_ignored();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter SIZESRDYN, 16, dynamic segment length in bits (2..127) SHALL be provided.
REQ-002 Parameter SIZESRSTAT, 88, static segment length in bits (2..127) SHALL be provided.
REQ-003 Parameter GAP_CYCLES, 4, idle cycles inserted between segments/frames (1..127) SHALL be provided.
REQ-004 Parameter CNT_W, 7, bit-counter width SHALL be provided.
REQ-005 Port CLK  in  1  system clock; all state SHALL update on its rising edge.
REQ-006 Port RST_N  in  1  reset, asynchronous, active-low.
REQ-007 Port START  in  1  frame-sequence request; SHALL be sampled in IDLE only.
REQ-008 Port ABORT  in  1  terminate sequence.
REQ-009 Port MODE  in  2  order: 00 dyn only, 01 stat only, 10 dyn then stat, 11 stat then dyn.
REQ-010 Port REPEAT  in  4  additional frames after the first (0..15).
REQ-011 Port SELDYN  out  1  dynamic shift-window select to the downstream generator.
REQ-012 Port SELSTAT  out  1  static shift-window select to the downstream generator.
REQ-013 Port BIT_VALID  out  1  SELDYN|SELSTAT delayed one cycle, aligned to the generator's registered serial output.
REQ-014 Port BUSY  out  1  high in every state except IDLE.
REQ-015 Port DONE  out  1  one-cycle pulse on normal completion.
REQ-016 Port FRAME_CNT  out  4  completed frames in current/last sequence.

Function
REQ-017 FSM states SHALL be IDLE, SEG1, GAP, SEG2, DONE.
REQ-018 IDLE with START=1 and ABORT=0 SHALL latch MODE and REPEAT, clear FRAME_CNT, load bit counter, enter SEG1.
REQ-019 SEG1/SEG2 SHALL assert exactly one select (per MODE order) for exactly the segment length in cycles, via down-counter length-1..0.
REQ-020 SELDYN and SELSTAT SHALL never be high in the same cycle.
REQ-021 Modes 00/01 SHALL skip SEG2; frame ends after SEG1.
REQ-022 At frame end FRAME_CNT SHALL increment; if frames remaining go to GAP (then SEG1), else DONE.
REQ-023 Between SEG1 and SEG2 (modes 10/11) the FSM SHALL pass through GAP.
REQ-024 DONE SHALL last one cycle with DONE=1, then IDLE.
REQ-025 START while not IDLE SHALL be ignored; MODE/REPEAT changes mid-sequence SHALL have no effect.
REQ-026 ABORT=1 in any non-IDLE state SHALL force IDLE next cycle, selects low, no DONE pulse, FRAME_CNT held.
REQ-027 ABORT and START together in IDLE: ABORT wins, FSM stays IDLE.
REQ-028 First select cycle SHALL be the cycle after the START sampling edge (latency 1).

Reset
REQ-029 RST_N low SHALL immediately force IDLE, SELDYN=0, SELSTAT=0, BIT_VALID=0, BUSY=0, DONE=0, FRAME_CNT=0, counters 0, including mid-sequence.

Configuration
REQ-030 With SHIFT_SEQ_GAP_EN defined, GAP SHALL hold selects low for GAP_CYCLES cycles.
REQ-031 Without SHIFT_SEQ_GAP_EN, GAP state and its counter SHALL be compiled out; segments and frames SHALL run back-to-back.

Structure
REQ-032 Package shift_seq_pkg SHALL hold the state enum, MODE encodings and default SIZESRDYN/SIZESRSTAT/GAP_CYCLES constants.
REQ-033 One sub-module seg_counter (loadable CNT_W down-counter with zero flag) SHALL be used for bit and gap counting.

Verification (cycle 0 = START sampling edge)
REQ-034 MODE=00, REPEAT=0 -> SELDYN cycles 1-16, BIT_VALID 2-17, DONE cycle 17, FRAME_CNT=1.
REQ-035 MODE=10, REPEAT=0, gap on -> SELDYN 1-16, idle 17-20, SELSTAT 21-108, DONE 109; gap off -> SELSTAT 17-104, DONE 105.
REQ-036 MODE=01, REPEAT=2, gap on -> SELSTAT 1-88, 93-180, 185-272, DONE 273, FRAME_CNT=3.
REQ-037 MODE=00, ABORT during cycle 10 -> SELDYN/BUSY low from cycle 11, no DONE; START+ABORT in IDLE -> no activity.
REQ-038 RST_N low at cycle 50 of MODE=11 -> all outputs 0 immediately; new START after release restarts at SELSTAT.
REQ-039 START pulsed during cycle 5 of busy sequence -> ignored, DONE count unchanged.
